// File: rtl/game_pkg.sv
// Shared definitions for the Flappy Bird game sequencer and the blocks that consume its state.
package game_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PLAY   = 2'd1,
    ST_PAUSED = 2'd2,
    ST_OVER   = 2'd3
  } state_t;

  localparam int SCORE_W_DEF = 8;
endpackage

// File: rtl/game_ctrl_btn_debounce.sv
// Button debouncer: accepts a level change after DEBOUNCE_CYCLES stable cycles, pulses on accepted rises.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_lvl;
  logic          r_arm;
  logic          r_press;

  // r_arm stays low until the input has been seen released, so a button held
  // through reset cannot produce a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_lvl   <= 1'b0;
      r_arm   <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_press <= 1'b0;
      if (!in && !r_lvl) r_arm <= 1'b1;
      if (in == r_lvl) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_lvl   <= in;
        r_press <= in & r_arm;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;
endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: input conditioning, IDLE/PLAY/PAUSED/OVER FSM, frame gating, score and restart hold-off.
module game_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int OVER_HOLD_FRAMES = 120,
  parameter int SCORE_W          = SCORE_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sw,
  input  logic               btn,
  input  logic               frame_tick,
  input  logic               collide,
  input  logic               pipe_passed,
  output logic [1:0]         state,
  output logic               frame_en,
  output logic               flap,
  output logic               world_clr,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);
  localparam int HOLD_W = $clog2(OVER_HOLD_FRAMES + 1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX  = HOLD_W'(OVER_HOLD_FRAMES);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  logic [1:0]         r_sw_s, r_btn_s;
  state_t             r_state, w_next;
  logic [SCORE_W-1:0] r_score, w_score;
  logic [HOLD_W-1:0]  r_hold, w_hold;
  logic               r_frame_en, r_flap, r_clr, r_over;
  logic               w_frame_en, w_flap, w_clr;
  logic               w_press, w_pause;

  // Synchronisers carry no reset; they only ever hold sampled pin values.
  always_ff @(posedge clk) begin
    r_sw_s  <= {r_sw_s[0], sw};
    r_btn_s <= {r_btn_s[0], btn};
  end

  assign w_pause = ~r_sw_s[1];

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
    .clk   (clk),
    .rst   (rst),
    .in    (r_btn_s[1]),
    .press (w_press)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_score    <= '0;
      r_hold     <= '0;
      r_frame_en <= 1'b0;
      r_flap     <= 1'b0;
      r_clr      <= 1'b0;
      r_over     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_score    <= w_score;
      r_hold     <= w_hold;
      r_frame_en <= w_frame_en;
      r_flap     <= w_flap;
      r_clr      <= w_clr;
      r_over     <= (w_next == ST_OVER);
    end
  end

  always_comb begin
    w_next     = r_state;
    w_score    = r_score;
    w_hold     = r_hold;
    w_frame_en = 1'b0;
    w_flap     = 1'b0;
    w_clr      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_score = '0;
        if (w_press && !w_pause) begin
          w_next = ST_PLAY;
          w_clr  = 1'b1;
        end
      end
      ST_PLAY: begin
        w_frame_en = frame_tick;
        // Collision wins outright: no flap and no score on that cycle.
        if (collide) begin
          w_next = ST_OVER;
          w_hold = '0;
        end else begin
          if (pipe_passed && r_score != SCORE_MAX) w_score = r_score + 1'b1;
          if (w_pause) w_next = ST_PAUSED;
          else         w_flap = w_press;
        end
      end
      ST_PAUSED: begin
        if (!w_pause) w_next = ST_PLAY;
      end
      ST_OVER: begin
        if (frame_tick && r_hold != HOLD_MAX) w_hold = r_hold + 1'b1;
        if (w_press && r_hold == HOLD_MAX) begin
          w_next  = ST_IDLE;
          w_score = '0;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign state     = r_state;
  assign frame_en  = r_frame_en;
  assign flap      = r_flap;
  assign world_clr = r_clr;
  assign score     = r_score;
  assign game_over = r_over;
endmodule

// File: tb/tb_game_ctrl.sv
// Bench for game_ctrl: directed scenarios plus random stimulus, checked each cycle against a behavioural model.
module tb_game_ctrl;
  localparam int N  = 4;
  localparam int H  = 3;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          clk, rst, sw, btn, frame_tick, collide, pipe_passed;
  logic [1:0]    state;
  logic          frame_en, flap, world_clr, game_over;
  logic [SW-1:0] score;

  game_ctrl #(.DEBOUNCE_CYCLES(N), .OVER_HOLD_FRAMES(H), .SCORE_W(SW)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn), .frame_tick(frame_tick),
    .collide(collide), .pipe_passed(pipe_passed), .state(state),
    .frame_en(frame_en), .flap(flap), .world_clr(world_clr),
    .score(score), .game_over(game_over)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int n_fe = 0, n_flap = 0, n_clr = 0;

  // ---------------- behavioural model ----------------
  // Board pins reach the logic two samples late; the button level is accepted
  // once the same raw value has been seen N samples in a row.
  bit  mvalid = 0;
  bit  b0, b1, s0, s1;
  int  prev_in, run;
  bit  lvl, armed, m_press;
  int  m_state, m_score, m_hold;
  bit  m_fe, m_flap, m_clr, m_go;
  bit  in_b, pause, pr, arm_before;

  always @(posedge clk) begin
    in_b  = b1;
    pause = !s1;
    b1 = b0; b0 = btn;
    s1 = s0; s0 = sw;
    if (rst) begin
      mvalid = 1; prev_in = -1; run = 0; lvl = 0; armed = 0; m_press = 0;
      m_state = 0; m_score = 0; m_hold = 0;
      m_fe = 0; m_flap = 0; m_clr = 0; m_go = 0;
    end else begin
      pr = m_press;
      run = (int'(in_b) == prev_in) ? run + 1 : 1;
      prev_in = int'(in_b);
      arm_before = armed;
      if (!in_b && !lvl) armed = 1;
      m_press = 0;
      if (run >= N && in_b != lvl) begin
        lvl = in_b;
        m_press = in_b && arm_before;
      end
      m_fe = 0; m_flap = 0; m_clr = 0;
      case (m_state)
        0: begin
          m_score = 0;
          if (pr && !pause) begin m_state = 1; m_clr = 1; end
        end
        1: begin
          m_fe = frame_tick;
          if (collide) begin
            m_state = 3; m_hold = 0;
          end else begin
            if (pipe_passed && m_score < SMAX) m_score = m_score + 1;
            if (pause) m_state = 2;
            else       m_flap = pr;
          end
        end
        2: if (!pause) m_state = 1;
        default: begin
          if (pr && m_hold == H) begin
            m_state = 0; m_score = 0;
          end
          if (frame_tick && m_hold < H) m_hold = m_hold + 1;
        end
      endcase
      m_go = (m_state == 3);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (frame_en)  n_fe++;
    if (flap)      n_flap++;
    if (world_clr) n_clr++;
    if (mvalid) begin
      total++;
      if (state !== 2'(m_state) || score !== SW'(m_score) || frame_en !== m_fe ||
          flap !== m_flap || world_clr !== m_clr || game_over !== m_go) begin
        bad++;
        $display("FAIL model t=%0t: got st=%0d sc=%0d fe=%0b fl=%0b clr=%0b go=%0b want st=%0d sc=%0d fe=%0b fl=%0b clr=%0b go=%0b",
                 $time, state, score, frame_en, flap, world_clr, game_over,
                 m_state, m_score, m_fe, m_flap, m_clr, m_go);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic press_for(input int n);
    btn = 1'b1; cyc(n);
    btn = 1'b0; cyc(10);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(2);
    end
  endtask

  task automatic pipes(input int n);
    for (int i = 0; i < n; i++) begin
      pipe_passed = 1'b1; cyc(1);
      pipe_passed = 1'b0; cyc(1);
    end
  endtask

  int c_fe, c_flap, c_clr, btn_left, sw_left;

  initial begin
    rst = 1'b1; sw = 1'b1; btn = 1'b0;
    frame_tick = 1'b0; collide = 1'b0; pipe_passed = 1'b0;
    cyc(3);
    rst = 1'b0; cyc(3);
    chk("reset_state", state, 0);
    chk("reset_score", score, 0);

    // start a game
    c_clr = n_clr; c_flap = n_flap;
    press_for(10);
    chk("start_state", state, 1);
    chk("start_clr", n_clr - c_clr, 1);
    chk("start_noflap", n_flap - c_flap, 0);
    c_fe = n_fe;
    ticks(5);
    chk("play_frame_en", n_fe - c_fe, 5);

    // debounce
    c_flap = n_flap;
    btn = 1'b1; cyc(2); btn = 1'b0; cyc(10);
    chk("glitch_noflap", n_flap - c_flap, 0);
    press_for(20);
    chk("held_one_flap", n_flap - c_flap, 1);

    // pause
    sw = 1'b0; cyc(3);
    chk("paused_state", state, 2);
    c_fe = n_fe; c_flap = n_flap; c_clr = n_clr;
    ticks(3);
    press_for(10);
    chk("paused_no_fe", n_fe - c_fe, 0);
    chk("paused_no_flap", n_flap - c_flap, 0);
    sw = 1'b1; cyc(4);
    chk("resume_state", state, 1);
    chk("resume_no_clr", n_clr - c_clr, 0);

    // score saturation, then collide with pipe_passed
    pipes(17);
    chk("score_sat", score, 15);
    collide = 1'b1; pipe_passed = 1'b1; cyc(1);
    collide = 1'b0; pipe_passed = 1'b0; cyc(1);
    chk("collide_state", state, 3);
    chk("collide_score", score, 15);
    ticks(3);
    press_for(10);
    chk("restart_idle", state, 0);
    chk("restart_score", score, 0);

    // collide together with pause request
    press_for(10);
    chk("game2_state", state, 1);
    pipes(3);
    sw = 1'b0; cyc(2);
    collide = 1'b1; cyc(1);
    collide = 1'b0;
    chk("cp_state", state, 3);
    chk("cp_game_over", game_over, 1);
    sw = 1'b1; cyc(1);
    ticks(2);
    press_for(10);
    chk("early_press_ignored", state, 3);
    chk("over_score_frozen", score, 3);
    ticks(1);
    press_for(10);
    chk("late_press_idle", state, 0);
    chk("late_press_score", score, 0);

    // reset mid-game, button held through reset
    press_for(10);
    pipes(6);
    chk("pre_reset_score", score, 6);
    btn = 1'b1; cyc(2);
    rst = 1'b1; cyc(1);
    rst = 1'b0;
    chk("rst_state", state, 0);
    chk("rst_score", score, 0);
    chk("rst_pulses", {frame_en, flap, world_clr, game_over}, 0);
    cyc(15);
    chk("held_no_start", state, 0);
    btn = 1'b0; cyc(10);
    press_for(10);
    chk("repress_start", state, 1);

    // random phase
    btn_left = 0; sw_left = 20;
    for (int i = 0; i < 4000; i++) begin
      if (btn_left == 0) begin btn = ~btn; btn_left = $urandom_range(1, 12); end
      else btn_left--;
      if (sw_left == 0) begin sw = ~sw; sw_left = sw ? $urandom_range(20, 200) : $urandom_range(1, 30); end
      else sw_left--;
      frame_tick  = ($urandom_range(0, 5) == 0);
      collide     = ($urandom_range(0, 60) == 0);
      pipe_passed = ($urandom_range(0, 6) == 0);
      rst         = ($urandom_range(0, 700) == 0);
      cyc(1);
    end
    rst = 1'b0; frame_tick = 1'b0; collide = 1'b0; pipe_passed = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
